// File: rtl/matmul_stream_host.sv
// Host-side stream front/back end for the 4x4-tiled systolic matrix multiplier.
// Loads A then B from one element stream, runs the multiplier, then streams C out row-major.
module matmul_stream_host #(
    parameter int unsigned M        = 16,
    parameter int unsigned K        = 16,
    parameter int unsigned N        = 16,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MIN_WAIT = (M / 4) * (N / 4) * (K / 4) * (K + 4) + 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   mm_start,
    output logic [WIDTH*M*K-1:0]   mm_a,
    output logic [WIDTH*K*N-1:0]   mm_b,
    input  logic [32*M*N-1:0]      mm_c,
    input  logic                   mm_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned NA   = M * K;
    localparam int unsigned NB   = K * N;
    localparam int unsigned NC   = M * N;
    localparam int unsigned NMAX = (NA > NB) ? NA : NB;
    localparam int unsigned IW   = $clog2(NMAX);
    localparam int unsigned AW   = $clog2(NA);
    localparam int unsigned BW   = $clog2(NB);
    localparam int unsigned OW   = $clog2(NC);
    localparam int unsigned WW   = $clog2(MIN_WAIT + 1);

    typedef enum logic [2:0] {StLoadA, StLoadB, StKick, StWait, StDrain} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [OW-1:0]     oidx_q, oidx_d;
    logic [WW-1:0]     wcnt_q, wcnt_d, wcnt_inc;
    logic              in_ready_q, mm_start_q, err_q, err_d;
    logic              in_hs, final_b, snap;
    logic [WIDTH-1:0]  a_q [NA];
    logic [WIDTH-1:0]  b_q [NB];
    logic [31:0]       c_q [NC];

    assign in_hs   = in_valid && in_ready_q;
    assign final_b = (state_q == StLoadB) && (idx_q == IW'(NB - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        oidx_d   = oidx_q;
        wcnt_d   = wcnt_q;
        snap     = 1'b0;
        wcnt_inc = (wcnt_q == WW'(MIN_WAIT)) ? wcnt_q : wcnt_q + WW'(1);
        // err only flags in_last misuse; the load itself is purely count-driven
        err_d    = err_q | (in_hs && (in_last != final_b));
        unique case (state_q)
            StLoadA: if (in_hs) begin
                if (idx_q == IW'(NA - 1)) begin
                    idx_d   = '0;
                    state_d = StLoadB;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StLoadB: if (in_hs) begin
                if (final_b) begin
                    idx_d   = '0;
                    state_d = StKick;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StKick: begin
                wcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wcnt_d = wcnt_inc;
                // A done seen before the minimum wait is a stale level from the previous job
                if (mm_done && (wcnt_inc == WW'(MIN_WAIT))) begin
                    snap    = 1'b1;
                    oidx_d  = '0;
                    state_d = StDrain;
                end
            end
            StDrain: if (out_ready) begin
                if (oidx_q == OW'(NC - 1)) begin
                    oidx_d  = '0;
                    state_d = StLoadA;
                end else begin
                    oidx_d = oidx_q + OW'(1);
                end
            end
            default: state_d = StLoadA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoadA;
            idx_q      <= '0;
            oidx_q     <= '0;
            wcnt_q     <= '0;
            in_ready_q <= 1'b0;
            mm_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            oidx_q     <= oidx_d;
            wcnt_q     <= wcnt_d;
            in_ready_q <= (state_d == StLoadA) || (state_d == StLoadB);
            mm_start_q <= (state_d == StKick) || (state_d == StWait);
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NA; i++) a_q[i] <= '0;
            for (int i = 0; i < NB; i++) b_q[i] <= '0;
            for (int i = 0; i < NC; i++) c_q[i] <= '0;
        end else begin
            if (in_hs && (state_q == StLoadA)) a_q[idx_q[AW-1:0]] <= in_data;
            if (in_hs && (state_q == StLoadB)) b_q[idx_q[BW-1:0]] <= in_data;
            if (snap) begin
                for (int i = 0; i < NC; i++) c_q[i] <= mm_c[32*i +: 32];
            end
        end
    end

    for (genvar g = 0; g < NA; g++) begin : g_mm_a
        assign mm_a[WIDTH*g +: WIDTH] = a_q[g];
    end
    for (genvar g = 0; g < NB; g++) begin : g_mm_b
        assign mm_b[WIDTH*g +: WIDTH] = b_q[g];
    end

    assign in_ready  = in_ready_q;
    assign mm_start  = mm_start_q;
    assign err       = err_q;
    assign out_valid = (state_q == StDrain);
    assign out_data  = (state_q == StDrain) ? c_q[oidx_q] : 32'd0;
    assign out_last  = (state_q == StDrain) && (oidx_q == OW'(NC - 1));
    assign busy      = !((state_q == StLoadA) && (idx_q == '0));

endmodule

// File: tb/tb_matmul_stream_host.sv
// Directed bench for matmul_stream_host at M=K=N=4 with a behavioural multiplier stub.
module tb_matmul_stream_host;

    typedef logic [15:0] vec16_t [16];
    typedef logic [31:0] vec32_t [16];

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, in_last;
    logic [15:0]    in_data;
    logic           mm_start, mm_done, done_r;
    logic [255:0]   mm_a, mm_b;
    logic [511:0]   mm_c;
    logic           out_valid, out_ready, out_last, busy, err;
    logic [31:0]    out_data;
    int             total = 0;
    int             bad   = 0;

    matmul_stream_host #(.M(4), .K(4), .N(4), .WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c),
        .mm_done   (mm_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign mm_done = done_r;

    // Multiplier stub; C is corrupted while draining so a late sample would show up.
    always_comb begin
        logic [31:0] acc;
        mm_c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc + 32'(mm_a[16*(4*i+k) +: 16]) * 32'(mm_b[16*(4*k+j) +: 16]);
                end
                mm_c[32*(4*i+j) +: 32] = acc ^ {32{out_valid}};
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input vec16_t a, input vec16_t b, input vec32_t exp, input int mode,
                           input bit bad_last, input bit late, input int abort_at);
        logic [15:0]  e [32];
        logic [255:0] ea, eb;
        int           i, t, cnt, k, c;
        bit           seen5;
        for (int j = 0; j < 16; j++) begin
            e[j]            = a[j];
            e[16+j]         = b[j];
            ea[16*j +: 16]  = a[j];
            eb[16*j +: 16]  = b[j];
        end
        if (late) done_r = 1'b0;
        i = 0; t = 0; seen5 = 1'b0;
        while (i < 32 && t < 300) begin
            @(negedge clk);
            t++;
            if (bad_last && i == 5 && !seen5) begin
                check("err_after_beat5", 256'(err), 256'(1));
                seen5 = 1'b1;
            end
            if (i == 1) check("busy_loading", 256'(busy), 256'(1));
            if (i == 31) check("start_low_before_last", 256'(mm_start), 256'(0));
            in_valid = 1'b1;
            in_data  = e[i];
            in_last  = bad_last ? (i == 4) : (i == 31);
            if (in_ready) i++;
        end
        check("load_count", 256'(i), 256'(32));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("start_after_last", 256'(mm_start), 256'(1));
        check("in_ready_kick", 256'(in_ready), 256'(0));
        check("mm_a", mm_a, ea);
        check("mm_b", mm_b, eb);
        cnt = 0; t = 0;
        while (!out_valid && t < 300) begin
            if (mm_start) cnt++;
            if (late && cnt == 20) done_r = 1'b1;
            @(negedge clk);
            t++;
        end
        check("start_cycles", 256'(cnt), 256'(late ? 20 : 13));
        check("start_low_drain", 256'(mm_start), 256'(0));
        k = 0; c = 0;
        while (k < 16 && c < 300) begin
            if (k == abort_at) break;
            out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (out_valid) begin
                check("out_data", 256'(out_data), 256'(exp[k]));
                check("out_last", 256'(out_last), 256'(k == 15));
                if (out_ready) k++;
            end else begin
                check("valid_in_drain", 256'(out_valid), 256'(1));
            end
            c++;
            @(negedge clk);
        end
        if (abort_at >= 0) begin
            check("abort_index", 256'(k), 256'(abort_at));
            rst_n = 1'b0;
            #1;
            check("rst_out_valid", 256'(out_valid), 256'(0));
            check("rst_out_data", 256'(out_data), 256'(0));
            check("rst_err", 256'(err), 256'(0));
            check("rst_mm_a", mm_a, 256'(0));
            check("rst_mm_b", mm_b, 256'(0));
            check("rst_busy", 256'(busy), 256'(0));
            check("rst_in_ready", 256'(in_ready), 256'(0));
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("in_ready_after_rst", 256'(in_ready), 256'(1));
            return;
        end
        check("drain_count", 256'(k), 256'(16));
        check("valid_after", 256'(out_valid), 256'(0));
        check("in_ready_after", 256'(in_ready), 256'(1));
        check("busy_after", 256'(busy), 256'(0));
        check("err_after", 256'(err), 256'(bad_last ? 1 : 0));
    endtask

    initial begin
        vec16_t ident, seq, twos, threes;
        vec32_t exp_seq, exp_24;
        for (int j = 0; j < 16; j++) begin
            ident[j]   = (j / 4 == j % 4) ? 16'd1 : 16'd0;
            seq[j]     = 16'(j + 1);
            twos[j]    = 16'd2;
            threes[j]  = 16'd3;
            exp_seq[j] = 32'(j + 1);
            exp_24[j]  = 32'd24;
        end
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; done_r = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready", 256'(in_ready), 256'(0));
        check("reset_mm_start", 256'(mm_start), 256'(0));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_out_data", 256'(out_data), 256'(0));
        check("reset_out_last", 256'(out_last), 256'(0));
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_err", 256'(err), 256'(0));
        check("reset_mm_a", mm_a, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_rise", 256'(in_ready), 256'(1));

        run_job(ident, seq, exp_seq, 0, 1'b0, 1'b0, -1);
        run_job(ident, seq, exp_seq, 1, 1'b0, 1'b0, -1);
        run_job(twos, threes, exp_24, 0, 1'b0, 1'b0, -1);
        run_job(ident, seq, exp_seq, 0, 1'b0, 1'b0, -1);
        run_job(ident, seq, exp_seq, 0, 1'b1, 1'b1, -1);
        run_job(ident, seq, exp_seq, 1, 1'b0, 1'b0, 7);
        run_job(ident, seq, exp_seq, 0, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
